// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards EX/MEM and MEM/WB
// results onto the ALU operands, and flags load-use hazards back to ID.
package id_ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } AluOp;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  AluOp            id_alu_op,
  input  logic            id_a_pc,
  input  logic            id_b_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic [2:0]      id_funct3,
  input  logic            mem_fwd_we,
  input  logic [RW-1:0]   mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_we,
  input  logic [RW-1:0]   wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RW-1:0]   ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output AluOp            alu_op,
  output logic [XLEN-1:0] ex_store_data
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [RW-1:0]   r_rs1;
  logic [RW-1:0]   r_rs2;
  logic [RW-1:0]   r_rd;
  logic [XLEN-1:0] r_raw1;
  logic [XLEN-1:0] r_raw2;
  logic [XLEN-1:0] r_imm;
  AluOp            r_op;
  logic            r_a_pc;
  logic            r_b_imm;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;
  logic [2:0]      r_funct3;

  logic            w_cap_hit1;
  logic            w_cap_hit2;
  logic [XLEN-1:0] w_cap1;
  logic [XLEN-1:0] w_cap2;
  logic            w_mem_hit1;
  logic            w_mem_hit2;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic            w_load_use;

  // Register-file write in the same cycle as the ID read is not yet visible there.
  assign w_cap_hit1 = wb_fwd_we && (wb_fwd_rd == id_rs1) && (id_rs1 != '0);
  assign w_cap_hit2 = wb_fwd_we && (wb_fwd_rd == id_rs2) && (id_rs2 != '0);
  assign w_cap1     = w_cap_hit1 ? wb_fwd_data : id_rs1_data;
  assign w_cap2     = w_cap_hit2 ? wb_fwd_data : id_rs2_data;

  assign w_mem_hit1 = mem_fwd_we && (mem_fwd_rd == r_rs1) && (r_rs1 != '0);
  assign w_mem_hit2 = mem_fwd_we && (mem_fwd_rd == r_rs2) && (r_rs2 != '0);
  assign w_wb_hit1  = wb_fwd_we && (wb_fwd_rd == r_rs1) && (r_rs1 != '0);
  assign w_wb_hit2  = wb_fwd_we && (wb_fwd_rd == r_rs2) && (r_rs2 != '0);

  assign w_fwd1 = w_mem_hit1 ? mem_fwd_data : (w_wb_hit1 ? wb_fwd_data : r_raw1);
  assign w_fwd2 = w_mem_hit2 ? mem_fwd_data : (w_wb_hit2 ? wb_fwd_data : r_raw2);

  assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                      ((r_rd == id_rs1) || (r_rd == id_rs2)) && !flush && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_raw1      <= '0;
      r_raw2      <= '0;
      r_imm       <= '0;
      r_op        <= ALU_ADD;
      r_a_pc      <= 1'b0;
      r_b_imm     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_funct3    <= '0;
    end else if (flush || w_load_use) begin
      // w_load_use is already masked by hold, so hold still beats the stall bubble.
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_raw1      <= '0;
      r_raw2      <= '0;
      r_imm       <= '0;
      r_op        <= ALU_ADD;
      r_a_pc      <= 1'b0;
      r_b_imm     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_funct3    <= '0;
    end else if (hold) begin
      // A writer retiring from WB during the hold would otherwise vanish.
      if (w_wb_hit1) r_raw1 <= wb_fwd_data;
      if (w_wb_hit2) r_raw2 <= wb_fwd_data;
    end else begin
      r_valid     <= id_valid;
      r_pc        <= id_pc;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_raw1      <= w_cap1;
      r_raw2      <= w_cap2;
      r_imm       <= id_imm;
      r_op        <= id_alu_op;
      r_a_pc      <= id_a_pc;
      r_b_imm     <= id_b_imm;
      r_reg_write <= id_valid && id_reg_write;
      r_mem_read  <= id_valid && id_mem_read;
      r_mem_write <= id_valid && id_mem_write;
      r_branch    <= id_valid && id_branch;
      r_funct3    <= id_funct3;
    end
  end

  assign load_use_stall = w_load_use;
  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rd          = r_rd;
  assign ex_funct3      = r_funct3;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_branch      = r_branch;
  assign alu_x          = r_a_pc ? r_pc : w_fwd1;
  assign alu_y          = r_b_imm ? r_imm : w_fwd2;
  assign alu_op         = r_op;
  assign ex_store_data  = w_fwd2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, x0 guard, load-use,
// hold refresh, flush priority, PC-relative operands and asynchronous reset.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, hold, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  AluOp        id_alu_op;
  logic        id_a_pc, id_b_imm, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [2:0]  id_funct3;
  logic        mem_fwd_we, wb_fwd_we;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        load_use_stall, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [31:0] alu_x, alu_y, ex_store_data;
  AluOp        alu_op;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_a_pc(id_a_pc), .id_b_imm(id_b_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_funct3(id_funct3), .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = ALU_ADD;
    id_a_pc = 0; id_b_imm = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_branch = 0; id_funct3 = '0;
  endtask

  task automatic clear_fwd();
    mem_fwd_we = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_we = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
  endtask

  // Drive a register-register instruction into ID.
  task automatic set_rr(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input AluOp op);
    clear_id();
    id_valid = 1; id_reg_write = 1;
    id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_alu_op = op;
  endtask

  initial begin
    rst_n = 1; flush = 0; hold = 0;
    clear_id(); clear_fwd();
    #1 rst_n = 0;
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst_stall", 32'(load_use_stall), 32'd0);
    @(negedge clk); rst_n = 1;

    // add x5,x1,x2 then sub x6,x5,x1 with x5 forwarded
    set_rr(5'd1, 32'h5, 5'd2, 32'h7, 5'd5, ALU_ADD);
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_rd", 32'(ex_rd), 32'd5);
    chk("add_alu_x", alu_x, 32'h5);
    chk("add_alu_y", alu_y, 32'h7);
    chk("add_reg_write", 32'(ex_reg_write), 32'd1);
    set_rr(5'd5, 32'h0, 5'd1, 32'h3, 5'd6, ALU_SUB);
    tick();
    mem_fwd_we = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h11;
    #1;
    chk("raw_mem_alu_x", alu_x, 32'h11);
    chk("raw_alu_y", alu_y, 32'h3);
    chk("raw_alu_op", 32'(alu_op), 32'(ALU_SUB));
    wb_fwd_we = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h22;
    #1;
    chk("raw_mem_prio", alu_x, 32'h11);
    mem_fwd_we = 0;
    #1;
    chk("raw_wb_only", alu_x, 32'h22);
    clear_fwd();

    // x0 is never forwarded
    set_rr(5'd0, 32'h0, 5'd0, 32'h0, 5'd9, ALU_ADD);
    tick();
    mem_fwd_we = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD_BEEF;
    wb_fwd_we = 1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hCAFE_F00D;
    #1;
    chk("x0_alu_x", alu_x, 32'h0);
    chk("x0_store", ex_store_data, 32'h0);
    clear_fwd();

    // lw x7,4(x2) followed by add x8,x7,x7
    clear_id();
    id_valid = 1; id_rs1 = 5'd2; id_rs1_data = 32'h1000; id_b_imm = 1; id_imm = 32'h4;
    id_rd = 5'd7; id_reg_write = 1; id_mem_read = 1; id_funct3 = 3'b010;
    tick();
    chk("lw_alu_x", alu_x, 32'h1000);
    chk("lw_alu_y", alu_y, 32'h4);
    chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
    chk("lw_funct3", 32'(ex_funct3), 32'd2);
    set_rr(5'd7, 32'h0, 5'd7, 32'h0, 5'd8, ALU_ADD);
    #1;
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
    chk("lu_bubble_rd", 32'(ex_rd), 32'd0);
    chk("lu_stall_drop", 32'(load_use_stall), 32'd0);
    tick();
    wb_fwd_we = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h1234;
    #1;
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rd", 32'(ex_rd), 32'd8);
    chk("lu_alu_x", alu_x, 32'h1234);
    chk("lu_alu_y", alu_y, 32'h1234);
    clear_fwd();

    // hold with a WB writer retiring to rs2=x9 mid-hold
    set_rr(5'd3, 32'h10, 5'd9, 32'h0, 5'd10, ALU_ADD);
    tick();
    chk("hd_alu_y_pre", alu_y, 32'h0);
    hold = 1;
    set_rr(5'd4, 32'h99, 5'd4, 32'h99, 5'd11, ALU_XOR);
    tick();
    wb_fwd_we = 1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'hA5A5_A5A5;
    tick();
    clear_fwd();
    #1;
    chk("hd_refresh", alu_y, 32'hA5A5_A5A5);
    tick();
    chk("hd_rd_kept", 32'(ex_rd), 32'd10);
    chk("hd_alu_x_kept", alu_x, 32'h10);
    hold = 0;
    #1;
    chk("hd_release_y", alu_y, 32'hA5A5_A5A5);

    // flush beats hold
    set_rr(5'd1, 32'h1, 5'd2, 32'h2, 5'd12, ALU_OR);
    id_branch = 1; id_mem_write = 1;
    flush = 1; hold = 1;
    tick();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_reg_write", 32'(ex_reg_write), 32'd0);
    chk("fl_branch", 32'(ex_branch), 32'd0);
    chk("fl_mem_write", 32'(ex_mem_write), 32'd0);
    chk("fl_alu_op", 32'(alu_op), 32'(ALU_ADD));
    flush = 0; hold = 0;

    // flush during a load-use hazard: stall suppressed, bubble loaded
    clear_id();
    id_valid = 1; id_rs1 = 5'd2; id_rd = 5'd7; id_reg_write = 1; id_mem_read = 1;
    tick();
    set_rr(5'd7, 32'h0, 5'd1, 32'h0, 5'd8, ALU_ADD);
    flush = 1;
    #1;
    chk("fl_lu_suppress", 32'(load_use_stall), 32'd0);
    tick();
    chk("fl_lu_valid", 32'(ex_valid), 32'd0);
    flush = 0;

    // PC-relative operands, with a same-cycle WB write bypassed into rs2
    clear_id();
    id_valid = 1; id_a_pc = 1; id_pc = 32'h100; id_b_imm = 1; id_imm = 32'h2000;
    id_rd = 5'd4; id_rs2 = 5'd6; id_rs2_data = 32'h0; id_reg_write = 1;
    wb_fwd_we = 1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h77;
    tick();
    clear_fwd();
    #1;
    chk("pc_alu_x", alu_x, 32'h100);
    chk("pc_alu_y", alu_y, 32'h2000);
    chk("pc_ex_pc", ex_pc, 32'h100);
    chk("cap_bypass_store", ex_store_data, 32'h77);

    // asynchronous reset in the middle of a hold
    hold = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_alu_x", alu_x, 32'h0);
    chk("arst_ex_pc", ex_pc, 32'h0);
    chk("arst_reg_write", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    rst_n = 1; hold = 0;
    set_rr(5'd1, 32'h42, 5'd2, 32'h43, 5'd13, ALU_AND);
    tick();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_alu_x", alu_x, 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
